// File: rtl/count_display_pkg.sv
// Shared types, segment table and sizing helper for the count_display slice.
package count_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    typedef enum logic {
        DIG_UNITS = 1'b0,
        DIG_TENS  = 1'b1
    } digit_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        if (nib <= 4'd9) return SEG_LUT[nib];
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/count_display_bin2bcd.sv
// Sequential shift-add-3 binary to two-digit BCD converter.
module bin2bcd_seq
    import count_display_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [3:0]   tens,
    output logic [3:0]   units
);

    localparam int unsigned BW = clog2(W);

    conv_state_e      state_q, state_d;
    logic [W-1:0]     bin_q, bin_d;
    logic [7:0]       bcd_q, bcd_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       units_q, units_d;
    logic [7:0]       adj;
    logic [W+7:0]     sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            bitcnt_q <= '0;
            tens_q   <= '0;
            units_q  <= '0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            bitcnt_q <= bitcnt_d;
            tens_q   <= tens_d;
            units_q  <= units_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        bitcnt_d = bitcnt_q;
        tens_d   = tens_q;
        units_d  = units_q;

        // Nibbles >= 5 get +3 before the shift so they carry correctly into the next digit.
        adj = bcd_q;
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        sh = {adj, bin_q} << 1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d    = bin;
                    bcd_d    = '0;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d    = sh[W+7:W];
                bin_d    = sh[W-1:0];
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == BW'(W - 1)) state_d = DONE;
            end
            DONE: begin
                tens_d  = bcd_q[7:4];
                units_d = bcd_q[3:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign tens  = tens_q;
    assign units = units_q;

endmodule

// File: rtl/count_display.sv
// Shows a binary count in decimal on two multiplexed active-low 7-segment digits.
module count_display
    import count_display_pkg::*;
#(
    parameter int unsigned W             = 6,
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned SCAN_HZ       = 1_000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] count,
    output logic [6:0]   seg,
    output logic [1:0]   an,
    output logic         busy
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned SW  = clog2(DIV);

    logic [W-1:0]  last_count_q, last_count_d;
    logic [W-1:0]  conv_val_q, conv_val_d;
    logic          force_conv_q, force_conv_d;
    logic          disp_valid_q, disp_valid_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    digit_e        sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    logic          start;
    logic          conv_busy;
    logic          conv_done;
    logic [3:0]    tens;
    logic [3:0]    units;
    logic          scan_wrap;

    assign start = force_conv_q | (count != last_count_q);

    bin2bcd_seq #(
        .W (W)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (count),
        .busy  (conv_busy),
        .done  (conv_done),
        .tens  (tens),
        .units (units)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_count_q <= '0;
            conv_val_q   <= '0;
            force_conv_q <= 1'b1;
            disp_valid_q <= 1'b0;
            scan_cnt_q   <= '0;
            sel_q        <= DIG_UNITS;
            seg_q        <= SEG_BLANK;
            an_q         <= 2'b11;
        end else begin
            last_count_q <= last_count_d;
            conv_val_q   <= conv_val_d;
            force_conv_q <= force_conv_d;
            disp_valid_q <= disp_valid_d;
            scan_cnt_q   <= scan_cnt_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    always_comb begin
        last_count_d = last_count_q;
        conv_val_d   = conv_val_q;
        force_conv_d = force_conv_q;
        disp_valid_d = disp_valid_q;

        // The converter scrambles its own copy while shifting, so keep the accepted value here.
        if (start && !conv_busy) conv_val_d = count;
        if (conv_done) begin
            last_count_d = conv_val_q;
            force_conv_d = 1'b0;
            disp_valid_d = 1'b1;
        end

        scan_wrap  = (scan_cnt_q == SW'(DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        sel_d      = sel_q;
        if (scan_wrap) sel_d = (sel_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;

        // Decode from the next select so seg/an switch on the same edge as the digit.
        seg_d = SEG_BLANK;
        an_d  = 2'b11;
        if (disp_valid_q) begin
            if (sel_d == DIG_UNITS) begin
                an_d  = 2'b10;
                seg_d = seg_decode(units);
            end else if (!(BLANK_LEADING && (tens == 4'd0))) begin
                an_d  = 2'b01;
                seg_d = seg_decode(tens);
            end
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = conv_busy;

endmodule

// File: tb/tb_count_display.sv
// Directed scoreboard bench for count_display, with and without leading-zero blanking.
module tb_count_display;

    localparam int unsigned W = 6;

    typedef struct {
        logic [3:0] t;
        logic [3:0] u;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [5:0] count;
    logic [6:0] seg1, seg0;
    logic [1:0] an1, an0;
    logic       busy1, busy0;

    int   n_tests;
    int   n_fail;
    int   busy_rises;
    logic prev_busy;
    exp_t sb[$];

    count_display #(
        .W             (6),
        .CLK_HZ        (8),
        .SCAN_HZ       (2),
        .BLANK_LEADING (1'b1)
    ) dut_blank (
        .clk   (clk),
        .rst   (rst),
        .count (count),
        .seg   (seg1),
        .an    (an1),
        .busy  (busy1)
    );

    count_display #(
        .W             (6),
        .CLK_HZ        (8),
        .SCAN_HZ       (2),
        .BLANK_LEADING (1'b0)
    ) dut_noblank (
        .clk   (clk),
        .rst   (rst),
        .count (count),
        .seg   (seg0),
        .an    (an0),
        .busy  (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] lut(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic seg_legal(input logic [6:0] s);
        if (s == 7'h7F) return 1'b1;
        for (int i = 0; i < 10; i++) if (s == lut(4'(i))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("an_not_both_blank", {7'd0, an1 == 2'b00}, 8'd0);
        chk("an_not_both_noblank", {7'd0, an0 == 2'b00}, 8'd0);
        chk("seg_legal_blank", {7'd0, seg_legal(seg1)}, 8'd1);
        chk("seg_legal_noblank", {7'd0, seg_legal(seg0)}, 8'd1);
        if (!prev_busy && busy1) busy_rises++;
        prev_busy = busy1;
    endtask

    task automatic drive(input int v);
        exp_t e;
        count = 6'(v);
        e.t = 4'(v / 10);
        e.u = 4'(v % 10);
        sb.push_back(e);
    endtask

    task automatic wait_done(output int len, output int edges);
        bit saw;
        bit ok;
        saw   = busy1;
        ok    = 1'b0;
        len   = 0;
        edges = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            edges++;
            if (busy1) begin
                saw = 1'b1;
                len++;
            end else if (saw) begin
                ok = 1'b1;
                break;
            end
        end
        chk("conv_finished_in_budget", {7'd0, ok}, 8'd1);
    endtask

    task automatic check_disp(input string tag, input logic [1:0] an_v, input logic [6:0] seg_v,
                              input exp_t e, input bit blank);
        logic [1:0] ea;
        logic [6:0] es;
        if (an_v == 2'b10) begin
            chk({tag, "_units_seg"}, {1'b0, seg_v}, {1'b0, lut(e.u)});
        end else begin
            ea = (blank && e.t == 4'd0) ? 2'b11 : 2'b01;
            es = (blank && e.t == 4'd0) ? 7'h7F : lut(e.t);
            chk({tag, "_tens_an"}, {6'd0, an_v}, {6'd0, ea});
            chk({tag, "_tens_seg"}, {1'b0, seg_v}, {1'b0, es});
        end
    endtask

    // Pops the next expected digit pair and checks 2*DIV-1 samples, which must span both phases.
    task automatic check_window();
        exp_t e;
        bit   seen_u, seen_t;
        chk("sb_has_entry", {7'd0, sb.size() != 0}, 8'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        seen_u = 1'b0;
        seen_t = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_disp("disp_blank", an1, seg1, e, 1'b1);
            check_disp("disp_noblank", an0, seg0, e, 1'b0);
            if (an1 == 2'b10) seen_u = 1'b1; else seen_t = 1'b1;
        end
        chk("units_phase_seen", {7'd0, seen_u}, 8'd1);
        chk("tens_phase_seen", {7'd0, seen_t}, 8'd1);
    endtask

    initial begin
        int len, edges, run, rises0;
        bit found;
        logic [1:0] prev_an;

        n_tests    = 0;
        n_fail     = 0;
        busy_rises = 0;
        prev_busy  = 1'b0;
        rst        = 1'b0;
        count      = 6'd42;

        // Reset held with count=42: everything blank and idle.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_seg", {1'b0, seg1}, 8'h7F);
            chk("rst_an", {6'd0, an1}, 8'h03);
            chk("rst_an_noblank", {6'd0, an0}, 8'h03);
            chk("rst_busy", {7'd0, busy1}, 8'd0);
        end
        drive(42);
        rst = 1'b1;
        wait_done(len, edges);
        chk("busy_len_42", 8'(len), 8'(W + 1));
        chk("done_edge_42", 8'(edges), 8'(W + 2));
        check_window();

        // Each digit phase lasts DIV=4 clocks.
        prev_an = an1;
        found   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (prev_an != 2'b10 && an1 == 2'b10) begin
                found = 1'b1;
                break;
            end
            prev_an = an1;
        end
        chk("units_phase_found", {7'd0, found}, 8'd1);
        run = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (an1 == 2'b10) run++; else break;
        end
        chk("units_phase_len", 8'(run), 8'd4);
        chk("tens_an_42", {6'd0, an1}, 8'h01);
        chk("tens_seg_42", {1'b0, seg1}, 8'h19);
        run = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (an1 != 2'b10) run++; else break;
        end
        chk("tens_phase_len", 8'(run), 8'd4);
        chk("units_seg_42", {1'b0, seg1}, 8'h24);

        drive(5);
        wait_done(len, edges);
        chk("busy_len_5", 8'(len), 8'(W + 1));
        check_window();

        drive(63);
        wait_done(len, edges);
        check_window();

        drive(0);
        wait_done(len, edges);
        check_window();

        // Change arriving two cycles into a conversion triggers a second one.
        rises0 = busy_rises;
        drive(10);
        tick();
        tick();
        drive(11);
        wait_done(len, edges);
        check_window();
        wait_done(len, edges);
        check_window();
        chk("busy_pulses_10_11", 8'(busy_rises - rises0), 8'd2);

        // Reset mid-SHIFT blanks immediately; a fresh conversion follows release.
        count = 6'd37;
        tick();
        tick();
        tick();
        chk("busy_before_midrst", {7'd0, busy1}, 8'd1);
        rst = 1'b0;
        #1;
        chk("midrst_seg", {1'b0, seg1}, 8'h7F);
        chk("midrst_an", {6'd0, an1}, 8'h03);
        chk("midrst_an_noblank", {6'd0, an0}, 8'h03);
        chk("midrst_busy", {7'd0, busy1}, 8'd0);
        tick();
        tick();
        chk("midrst_hold_seg", {1'b0, seg1}, 8'h7F);
        drive(37);
        rst = 1'b1;
        wait_done(len, edges);
        chk("busy_len_37", 8'(len), 8'(W + 1));
        chk("done_edge_37", 8'(edges), 8'(W + 2));
        check_window();

        chk("sb_drained", 8'(sb.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
